// File: rtl/regfile_pkg.sv
// Shared definitions for the MIPS register file: address width, register count and the zero register.
package regfile_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address decode, register-0 forcing and, when REGFILE_BYPASS_EN is
// defined, write-through forwarding of the in-flight write data.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
    input  reg_addr_t             addr,
`ifdef REGFILE_BYPASS_EN
    input  logic                  we,
    input  reg_addr_t             rd,
    input  logic [DATA_WIDTH-1:0] data_in,
`endif
    output logic [DATA_WIDTH-1:0] data
);

    always_comb begin
        data = regs[addr];
`ifdef REGFILE_BYPASS_EN
        if (we && rd != ZERO_REG && rd == addr) begin
            data = data_in;
        end
`endif
        // Register 0 reads zero regardless of what the array holds.
        if (addr == ZERO_REG) begin
            data = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// MIPS general-purpose register file: 32 registers, two combinational read ports, one clocked write
// port, register 0 hardwired to zero. Optional write-through forwarding under REGFILE_BYPASS_EN.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  reg_addr_t             rd,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  reg_addr_t             rs,
    input  reg_addr_t             rt,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // No handshake: a write with we=1 and rd!=0 is accepted on every rising edge while rst=1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && rd != ZERO_REG) begin
            regs[rd] <= dataIn;
        end
    end

    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (
        .regs    (regs),
        .addr    (rs),
`ifdef REGFILE_BYPASS_EN
        .we      (we),
        .rd      (rd),
        .data_in (dataIn),
`endif
        .data    (A)
    );

    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (
        .regs    (regs),
        .addr    (rt),
`ifdef REGFILE_BYPASS_EN
        .we      (we),
        .rd      (rd),
        .data_in (dataIn),
`endif
        .data    (B)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized bench for register_file, checked against an array model of the register file.
module tb_register_file;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         we;
    logic [4:0]   rd;
    logic [W-1:0] dataIn;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [W-1:0] A;
    logic [W-1:0] B;

    logic [W-1:0] model [32];
    int n_compared;
    int n_mismatched;

    register_file #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .rd     (rd),
        .dataIn (dataIn),
        .rs     (rs),
        .rt     (rt),
        .A      (A),
        .B      (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value from the model, including forwarding when that build option is on.
    function automatic logic [W-1:0] exp_read(input logic [4:0] addr);
        logic [W-1:0] v;
        v = (addr == 5'd0) ? '0 : model[addr];
`ifdef REGFILE_BYPASS_EN
        if (we === 1'b1 && rd != 5'd0 && rd == addr) v = dataIn;
`endif
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [W-1:0] d);
        @(negedge clk);
        we = 1'b1; rd = a; dataIn = d;
        @(posedge clk);
        #1;
        if (a != 5'd0) model[a] = d;
        we = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [4:0] b);
        rs = a; rt = b;
        #1;
        check({tag, "_A"}, A, exp_read(a));
        check({tag, "_B"}, B, exp_read(b));
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        model_clear();
        we = 1'b0; rd = '0; dataIn = '0; rs = '0; rt = '0;
        rst = 1'b1;
        #2 rst = 1'b0;

        // Reset held for two cycles: every address reads zero.
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i);
            #1;
            check("reset_A", A, '0);
            check("reset_B", B, '0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Basic writes.
        do_write(5'd1, 32'd2001);
        do_write(5'd2, 32'd4001);
        do_write(5'd6, 32'd5001);
        do_write(5'd8, 32'd3001);
        rs = 5'd1; rt = 5'd2; #1;
        check("basic_r1", A, 32'd2001);
        check("basic_r2", B, 32'd4001);
        rs = 5'd6; rt = 5'd8; #1;
        check("basic_r6", A, 32'd5001);
        check("basic_r8", B, 32'd3001);

        // Write enable gating.
        @(negedge clk);
        we = 1'b0; rd = 5'd3; dataIn = 32'hDEADBEEF;
        @(posedge clk); #1;
        rs = 5'd3; #1;
        check("we_gate_r3", A, 32'd0);

        // Register zero discards writes.
        do_write(5'd0, 32'hFFFFFFFF);
        rs = 5'd0; rt = 5'd0; #1;
        check("zero_A", A, 32'd0);
        check("zero_B", B, 32'd0);

        // Asynchronous reset between edges.
        rs = 5'd1; rt = 5'd2;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_A", A, 32'd0);
        check("async_rst_B", B, 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        read_check("post_rst_1_2", 5'd1, 5'd2);
        read_check("post_rst_6_8", 5'd6, 5'd8);

        // Read-during-write on r5 (empty after reset).
        @(negedge clk);
        we = 1'b1; rd = 5'd5; rs = 5'd5; rt = 5'd5; dataIn = 32'd77;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before_edge", A, 32'd77);
`else
        check("rdw_before_edge", A, 32'd0);
`endif
        @(posedge clk); #1;
        model[5] = 32'd77;
        check("rdw_after_edge", A, 32'd77);
        we = 1'b0;

        // Randomized traffic checked against the model before and after each edge.
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 31));
            dataIn = $urandom;
            read_check("rand_pre", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            @(posedge clk); #1;
            if (we && rd != 5'd0) model[rd] = dataIn;
            we = 1'b0;
            read_check("rand_post", 5'($urandom_range(0, 31)), rd);
        end

        // Unknown write enable must leave every non-addressed register untouched.
        @(negedge clk);
        we = 1'bx; rd = 5'd5; dataIn = 32'hA5A5A5A5;
        @(posedge clk); #1;
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i != 5) begin
                rs = 5'(i); #1;
                check("x_we_other", A, exp_read(5'(i)));
            end
        end
        do_write(5'd5, 32'h12345678);
        read_check("x_we_resync", 5'd5, 5'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
